// File: rtl/seg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// seg_scan_ctrl
//   Time-multiplexing scan controller for a multi-digit 7-segment display.
//   The per-digit segment patterns are captured into a shadow register once per
//   frame, so a frame never mixes old and new digit values. One digit at a time
//   is driven onto the shared segment bus with a one-hot digit enable.
//
//   Optional feature macro: SEG_SCAN_GAP_EN
//     When defined, every digit slot is followed by GAP_CYCLES dead-time cycles.
//     During dead time no digit is lit, which suppresses ghosting. When the
//     macro is undefined, slots run back-to-back and GAP_CYCLES is ignored.
//
// Ports
//   clk          in   1                  system clock, rising edge
//   reset        in   1                  asynchronous, active-low reset
//   enable       in   1                  1 = scan running, 0 = display blanked
//   seg_in       in   NUM_DIGITS*SEG_W   digit d pattern at [d*SEG_W +: SEG_W]
//   seg_out      out  SEG_W              shared segment bus (BLANK when unlit)
//   digit_en     out  NUM_DIGITS         one-hot digit select, 0 = none lit
//   frame_start  out  1                  high for the first cycle of each frame
// -----------------------------------------------------------------------------
module seg_scan_ctrl #(
   parameter int               NUM_DIGITS = 2,
   parameter int               SEG_W      = 7,
   parameter int               PRESCALE   = 4,
   parameter int               GAP_CYCLES = 1,
   parameter logic [SEG_W-1:0] BLANK      = 7'h7F
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        enable,
   input  logic [NUM_DIGITS*SEG_W-1:0] seg_in,
   output logic [SEG_W-1:0]            seg_out,
   output logic [NUM_DIGITS-1:0]       digit_en,
   output logic                        frame_start
);

   localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   // The slot counter is shared between SHOW and GAP, so size it for the longer.
   localparam int CNT_MAX = (PRESCALE > GAP_CYCLES) ? PRESCALE : GAP_CYCLES;
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_SHOW = 2'd1;
`ifdef SEG_SCAN_GAP_EN
   localparam logic [1:0] ST_GAP  = 2'd2;
`endif

   logic [1:0]                  state_reg,  state_next;
   logic [IDX_W-1:0]            idx_reg,    idx_next;
   logic [CNT_W-1:0]            count_reg,  count_next;
   logic [NUM_DIGITS*SEG_W-1:0] shadow_reg, shadow_next;

   logic             idx_last;
   logic [IDX_W-1:0] idx_adv;
   logic             show;

   assign idx_last = (idx_reg == IDX_W'(NUM_DIGITS - 1));
   assign idx_adv  = idx_last ? '0 : idx_reg + IDX_W'(1);

   // Next-state logic. enable=0 overrides everything and parks the scanner;
   // the shadow keeps its contents but is never shown while idle.
   always_comb begin
      state_next  = state_reg;
      idx_next    = idx_reg;
      count_next  = count_reg;
      shadow_next = shadow_reg;
      if (!enable) begin
         state_next = ST_IDLE;
         idx_next   = '0;
         count_next = '0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               state_next  = ST_SHOW;
               idx_next    = '0;
               count_next  = '0;
               shadow_next = seg_in;
            end
            ST_SHOW: begin
               if (count_reg == CNT_W'(PRESCALE - 1)) begin
                  count_next = '0;
`ifdef SEG_SCAN_GAP_EN
                  state_next = ST_GAP;
`else
                  idx_next = idx_adv;
                  // Wrapping back to digit 0 starts a new frame: take a snapshot.
                  if (idx_last) begin
                     shadow_next = seg_in;
                  end
`endif
               end else begin
                  count_next = count_reg + CNT_W'(1);
               end
            end
`ifdef SEG_SCAN_GAP_EN
            ST_GAP: begin
               if (count_reg == CNT_W'(GAP_CYCLES - 1)) begin
                  state_next = ST_SHOW;
                  count_next = '0;
                  idx_next   = idx_adv;
                  if (idx_last) begin
                     shadow_next = seg_in;
                  end
               end else begin
                  count_next = count_reg + CNT_W'(1);
               end
            end
`endif
            default: begin
               state_next = ST_IDLE;
               idx_next   = '0;
               count_next = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg  <= ST_IDLE;
         idx_reg    <= '0;
         count_reg  <= '0;
         shadow_reg <= {NUM_DIGITS{BLANK}};
      end else begin
         state_reg  <= state_next;
         idx_reg    <= idx_next;
         count_reg  <= count_next;
         shadow_reg <= shadow_next;
      end
   end

   // Outputs are decoded from registers only, so reset blanks them immediately.
   assign show        = (state_reg == ST_SHOW);
   assign frame_start = show && (idx_reg == '0) && (count_reg == '0);

   always_comb begin
      seg_out = BLANK;
      if (show) begin
         for (int d = 0; d < NUM_DIGITS; d++) begin
            if (idx_reg == IDX_W'(d)) begin
               seg_out = shadow_reg[d*SEG_W +: SEG_W];
            end
         end
      end
   end

   generate
      for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit_en
         assign digit_en[gi] = show && (idx_reg == IDX_W'(gi));
      end
   endgenerate

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_seg_scan_ctrl
//   Self-checking bench for seg_scan_ctrl (NUM_DIGITS=2, PRESCALE=4).
//   The reference model tracks time since the scan (re)started and derives the
//   lit digit, slot position and snapshot moments with plain arithmetic.
// -----------------------------------------------------------------------------
module tb_seg_scan_ctrl;

   localparam int         N     = 2;
   localparam int         SW    = 7;
   localparam int         P     = 4;
   localparam int         G     = 1;
   localparam logic [6:0] BLANK = 7'h7F;
`ifdef SEG_SCAN_GAP_EN
   localparam int SLOT = P + G;
`else
   localparam int SLOT = P;
`endif
   localparam int FRAME = N * SLOT;

   logic            clk = 1'b0;
   logic            reset = 1'b0;
   logic            enable = 1'b0;
   logic [N*SW-1:0] seg_in = '0;
   logic [SW-1:0]   seg_out;
   logic [N-1:0]    digit_en;
   logic            frame_start;

   int errors = 0;
   int checks = 0;
   int ncyc   = 0;

   // reference model state
   bit            m_active = 1'b0;
   int            m_t      = 0;
   logic [SW-1:0] m_snap [N];
   logic [SW-1:0] exp_seg;
   logic [N-1:0]  exp_den;
   logic          exp_fs;

   seg_scan_ctrl #(
      .NUM_DIGITS (N),
      .SEG_W      (SW),
      .PRESCALE   (P),
      .GAP_CYCLES (G),
      .BLANK      (BLANK)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .enable      (enable),
      .seg_in      (seg_in),
      .seg_out     (seg_out),
      .digit_en    (digit_en),
      .frame_start (frame_start)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
      $fatal(1, "watchdog");
   end

   task automatic take_snapshot();
      for (int d = 0; d < N; d++) m_snap[d] = seg_in[d*SW +: SW];
   endtask

   task automatic model_expect();
      int pos;
      int d;
      exp_seg = BLANK;
      exp_den = '0;
      exp_fs  = 1'b0;
      if (m_active) begin
         pos = m_t % FRAME;
         d   = pos / SLOT;
         if ((pos % SLOT) < P) begin
            exp_den = N'(1) << d;
            exp_seg = m_snap[d];
            exp_fs  = (pos == 0);
         end
      end
   endtask

   // One clock edge: advance the model with the inputs the DUT sampled,
   // then settle and compute expectations.
   task automatic cycle();
      @(posedge clk);
      if (!reset || !enable) begin
         m_active = 1'b0;
      end else if (!m_active) begin
         m_active = 1'b1;
         m_t      = 0;
         take_snapshot();
      end else begin
         m_t++;
         if ((m_t % FRAME) == 0) take_snapshot();
      end
      #1;
      model_expect();
      ncyc++;
      $display("cyc=%0d en=%b seg_in=%h digit_en=%b seg_out=%h frame_start=%b",
               ncyc, enable, seg_in, digit_en, seg_out, frame_start);
   endtask

   task automatic test_reset();
      reset  = 1'b0;
      enable = 1'b1;
      seg_in = {7'h30, 7'h79};
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (seg_out !== 7'h7F || digit_en !== 2'b00 || frame_start !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: got seg=%h den=%b fs=%b, required seg=7f den=00 fs=0",
                  seg_out, digit_en, frame_start);
      end
      @(negedge clk);
      reset = 1'b1;
      cycle();
      checks++;
      if (seg_out !== 7'h79 || digit_en !== 2'b01 || frame_start !== 1'b1) begin
         errors++;
         $display("FAIL first_edge: got seg=%h den=%b fs=%b, required seg=79 den=01 fs=1",
                  seg_out, digit_en, frame_start);
      end
      cycle();
      checks++;
      if (frame_start !== 1'b0 || digit_en !== 2'b01) begin
         errors++;
         $display("FAIL fs_pulse_width: got fs=%b den=%b, required fs=0 den=01",
                  frame_start, digit_en);
      end
   endtask

   task automatic test_free_run();
      int last_fs = -1;
      for (int k = 0; k < 3 * FRAME; k++) begin
         cycle();
         checks++;
         if (seg_out !== exp_seg || digit_en !== exp_den || frame_start !== exp_fs) begin
            errors++;
            $display("FAIL free_run: got seg=%h den=%b fs=%b, required seg=%h den=%b fs=%b",
                     seg_out, digit_en, frame_start, exp_seg, exp_den, exp_fs);
         end
         if (frame_start === 1'b1) begin
            if (last_fs >= 0) begin
               checks++;
               if (ncyc - last_fs != FRAME) begin
                  errors++;
                  $display("FAIL frame_period: got %0d cycles, required %0d",
                           ncyc - last_fs, FRAME);
               end
            end
            last_fs = ncyc;
         end
      end
   endtask

   task automatic test_midframe_update();
      int guard = 0;
      while ((m_t % FRAME) != 1 && guard < 4 * FRAME) begin
         cycle();
         guard++;
      end
      checks++;
      if ((m_t % FRAME) != 1) begin
         errors++;
         $display("FAIL midframe_sync: got pos=%0d, required pos=1", m_t % FRAME);
      end
      seg_in[13:7] = 7'h24;
      for (int k = 0; k < FRAME - 1; k++) begin
         cycle();
         checks++;
         if (seg_out !== exp_seg || digit_en !== exp_den) begin
            errors++;
            $display("FAIL midframe_model: got seg=%h den=%b, required seg=%h den=%b",
                     seg_out, digit_en, exp_seg, exp_den);
         end
         if (digit_en === 2'b10) begin
            checks++;
            if (seg_out !== 7'h30) begin
               errors++;
               $display("FAIL no_tear: got seg=%h, required seg=30", seg_out);
            end
         end
      end
      for (int k = 0; k < FRAME; k++) begin
         cycle();
         if (digit_en === 2'b10) begin
            checks++;
            if (seg_out !== 7'h24) begin
               errors++;
               $display("FAIL next_frame_update: got seg=%h, required seg=24", seg_out);
            end
         end
      end
   endtask

   task automatic test_enable_drop();
      int guard = 0;
      while ((m_t % FRAME) != SLOT + 2 && guard < 4 * FRAME) begin
         cycle();
         guard++;
      end
      checks++;
      if (digit_en !== 2'b10) begin
         errors++;
         $display("FAIL drop_sync: got den=%b, required den=10", digit_en);
      end
      enable = 1'b0;
      cycle();
      checks++;
      if (seg_out !== 7'h7F || digit_en !== 2'b00 || frame_start !== 1'b0) begin
         errors++;
         $display("FAIL enable_drop: got seg=%h den=%b fs=%b, required seg=7f den=00 fs=0",
                  seg_out, digit_en, frame_start);
      end
      cycle();
      seg_in[6:0] = 7'h12;
      enable = 1'b1;
      cycle();
      checks++;
      if (seg_out !== 7'h12 || digit_en !== 2'b01 || frame_start !== 1'b1) begin
         errors++;
         $display("FAIL re_enable: got seg=%h den=%b fs=%b, required seg=12 den=01 fs=1",
                  seg_out, digit_en, frame_start);
      end
   endtask

   task automatic test_async_reset();
      repeat (5) cycle();
      #3;
      reset    = 1'b0;
      m_active = 1'b0;
      #1;
      checks++;
      if (seg_out !== 7'h7F || digit_en !== 2'b00 || frame_start !== 1'b0) begin
         errors++;
         $display("FAIL async_reset: got seg=%h den=%b fs=%b, required seg=7f den=00 fs=0",
                  seg_out, digit_en, frame_start);
      end
      @(negedge clk);
      reset = 1'b1;
      cycle();
      checks++;
      if (digit_en !== 2'b01 || frame_start !== 1'b1 || seg_out !== exp_seg) begin
         errors++;
         $display("FAIL after_reset: got seg=%h den=%b fs=%b, required seg=%h den=01 fs=1",
                  seg_out, digit_en, frame_start, exp_seg);
      end
   endtask

   task automatic test_random();
      for (int k = 0; k < 300; k++) begin
         if ($urandom_range(0, 7) == 0) seg_in = N*SW'($urandom);
         enable = ($urandom_range(0, 24) != 0);
         cycle();
         checks++;
         if (seg_out !== exp_seg || digit_en !== exp_den || frame_start !== exp_fs) begin
            errors++;
            $display("FAIL random: got seg=%h den=%b fs=%b, required seg=%h den=%b fs=%b",
                     seg_out, digit_en, frame_start, exp_seg, exp_den, exp_fs);
         end
         checks++;
         if ($countones(digit_en) > 1 || (digit_en === '0 && seg_out !== BLANK)) begin
            errors++;
            $display("FAIL invariant: got den=%b seg=%h, required onehot0 and blank when unlit",
                     digit_en, seg_out);
         end
      end
   endtask

   initial begin
      test_reset();
      test_free_run();
      test_midframe_update();
      test_enable_drop();
      test_async_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
